// File: rtl/lcd_pkg.sv
// Shared LCD bus types: nibble FSM states, HD44780 command bytes and default settle waits.
// Pure declarations; no latency or backpressure of its own.
package lcd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HI_EN,
      HI_LO,
      LO_EN,
      LO_LO,
      WAIT
   } lcd_state_t;

   localparam logic [7:0] CMD_CLEAR      = 8'h01;
   localparam logic [7:0] CMD_HOME       = 8'h02;
   localparam logic [7:0] CMD_FUNCSET_4B = 8'h28;
   localparam logic [7:0] CMD_DISPCTRL   = 8'h0C;
   localparam logic [7:0] CMD_ENTRYMODE  = 8'h06;
   localparam logic [7:0] CMD_DDRAM_ROW2 = 8'hC0;

   localparam int DEF_SHORT_WAIT = 0;
   localparam int DEF_LONG_WAIT  = 2;
   localparam int DEF_NIB_WAIT   = 5;
   localparam int WAIT_MAX       = 7;

   // Clear and home are the slow HD44780 commands that need the long settle.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] byte_val);
      return !rs && (byte_val == CMD_CLEAR || byte_val == CMD_HOME);
   endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin grant: combinational grant while enabled, last winner registered.
// Grant only ever goes to a valid requester; losers simply wait.
module lcd_rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [1:0] valid,
   output logic [1:0] grant
);

   logic last_grant;
   logic pick;

   always_comb begin
      pick = 1'b0;
      case (valid)
         2'b10:   pick = 1'b1;
         2'b11:   pick = ~last_grant;
         default: pick = 1'b0;
      endcase
      grant = {enable & valid[1] & pick, enable & valid[0] & ~pick};
   end

   // Reset to 1 so requester 0 wins the very first contested grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= 1'b1;
      end else if (|grant) begin
         last_grant <= grant[1];
      end
   end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Arbitrates two byte requesters onto the 4-bit LCD bus: high then low nibble with one-cycle EN pulses,
// then a settle wait; first EN one cycle after accept, requests stall (ready=0) whenever busy.
module lcd_bus_arbiter
   import lcd_pkg::*;
#(
   parameter int SHORT_WAIT = DEF_SHORT_WAIT,
   parameter int LONG_WAIT  = DEF_LONG_WAIT,
   parameter int NIB_WAIT   = DEF_NIB_WAIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic       req0_rs,
   input  logic       req0_nib,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic       req1_rs,
   input  logic       req1_nib,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       busy,
   output logic       en,
   output logic       rs,
   output logic [3:0] data
);

   generate
      if (SHORT_WAIT < 0 || SHORT_WAIT > WAIT_MAX ||
          LONG_WAIT  < 0 || LONG_WAIT  > WAIT_MAX ||
          NIB_WAIT   < 0 || NIB_WAIT   > WAIT_MAX) begin : g_bad_wait
         $error("lcd_bus_arbiter: wait parameters must be in 0..7");
      end
   endgenerate

   localparam logic [2:0] SHORT_W3 = 3'(SHORT_WAIT);
   localparam logic [2:0] LONG_W3  = 3'(LONG_WAIT);
   localparam logic [2:0] NIB_W3   = 3'(NIB_WAIT);

   lcd_state_t state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic [1:0] grant;
   logic       accept;
   logic       acc_rs, acc_nib;
   logic [7:0] acc_data;
   logic       lat_rs, lat_nib;
   logic [7:0] lat_data;

   lcd_rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .enable (state == IDLE),
      .valid  ({req1_valid, req0_valid}),
      .grant  (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign busy       = (state != IDLE);
   assign accept     = |grant;
   assign acc_rs     = grant[1] ? req1_rs   : req0_rs;
   assign acc_nib    = grant[1] ? req1_nib  : req0_nib;
   assign acc_data   = grant[1] ? req1_data : req0_data;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE:  if (accept) state_nxt = HI_EN;
         HI_EN: state_nxt = HI_LO;
         HI_LO: begin
            if (lat_nib) begin
               state_nxt = WAIT;
               cnt_nxt   = NIB_W3;
            end else begin
               state_nxt = LO_EN;
            end
         end
         LO_EN: state_nxt = LO_LO;
         LO_LO: begin
            state_nxt = WAIT;
            cnt_nxt   = is_long_cmd(lat_rs, lat_data) ? LONG_W3 : SHORT_W3;
         end
         // A count of 0 or 1 both leave after this single cycle.
         WAIT: begin
            if (cnt <= 3'd1) begin
               state_nxt = IDLE;
               cnt_nxt   = 3'd0;
            end else begin
               cnt_nxt = cnt - 3'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 3'd0;
         lat_rs   <= 1'b0;
         lat_nib  <= 1'b0;
         lat_data <= 8'h00;
         en       <= 1'b0;
         rs       <= 1'b0;
         data     <= 4'h0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         en    <= (state_nxt == HI_EN) || (state_nxt == LO_EN);
         // rs/data only move on the edge that raises en, so they hold between pulses.
         if (accept) begin
            lat_rs   <= acc_rs;
            lat_nib  <= acc_nib;
            lat_data <= acc_data;
            rs       <= acc_rs;
            data     <= acc_data[7:4];
         end
         if (state_nxt == LO_EN) begin
            data <= lat_data[3:0];
         end
      end
   end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench for lcd_bus_arbiter: directed byte writes push expected nibbles/grants,
// a negedge monitor pops and compares every EN pulse and every grant.
module tb_lcd_bus_arbiter;
   import lcd_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0_valid = 1'b0, req0_rs = 1'b0, req0_nib = 1'b0;
   logic [7:0] req0_data = 8'h00;
   logic       req0_ready;
   logic       req1_valid = 1'b0, req1_rs = 1'b0, req1_nib = 1'b0;
   logic [7:0] req1_data = 8'h00;
   logic       req1_ready;
   logic       busy, en, rs;
   logic [3:0] data;

   typedef struct {
      int         cyc;
      logic       rs;
      logic [3:0] d;
   } nib_t;

   nib_t exp_q[$];
   int   exp_gnt[$];
   int   vecs = 0;
   int   miss = 0;
   int   cyc  = 0;

   lcd_bus_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_rs    (req0_rs),
      .req0_nib   (req0_nib),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_rs    (req1_rs),
      .req1_nib   (req1_nib),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .busy       (busy),
      .en         (en),
      .rs         (rs),
      .data       (data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every EN pulse must match the head of the nibble queue; every grant the grant queue.
   logic       prev_en = 1'b0;
   logic       last_rs = 1'b0;
   logic [3:0] last_d  = 4'h0;
   nib_t       mon_e;
   int         mon_g;

   always @(negedge clk) begin
      if (reset) begin
         prev_en = 1'b0;
         last_rs = 1'b0;
         last_d  = 4'h0;
      end else begin
         if (en) begin
            chk("en_gap", {31'd0, prev_en}, 32'd0);
            if (exp_q.size() == 0) begin
               vecs++;
               miss++;
               $display("FAIL unexpected_pulse: rs=%0d data=%0h with nothing expected (cycle %0d)", rs, data, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               vecs++;
               if (rs !== mon_e.rs || data !== mon_e.d || (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
                  miss++;
                  $display("FAIL nibble: got rs=%0d data=%0h cycle %0d, expected rs=%0d data=%0h cycle %0d",
                           rs, data, cyc, mon_e.rs, mon_e.d, mon_e.cyc);
               end
               last_rs = mon_e.rs;
               last_d  = mon_e.d;
            end
         end else begin
            chk("bus_hold", {27'd0, rs, data}, {27'd0, last_rs, last_d});
         end
         prev_en = en;
         chk("ready_gate", {31'd0, (req0_ready && !req0_valid) || (req1_ready && !req1_valid) ||
                                   (req0_ready && req1_ready)}, 32'd0);
         for (int id = 0; id < 2; id++) begin
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
               if (exp_gnt.size() == 0) begin
                  vecs++;
                  miss++;
                  $display("FAIL unexpected_grant: requester %0d granted with none expected (cycle %0d)", id, cyc);
               end else begin
                  mon_g = exp_gnt.pop_front();
                  chk("grant_id", id, mon_g);
               end
            end
         end
      end
   end

   task automatic set_req(input int port, input logic v, input logic r, input logic nb, input logic [7:0] d);
      if (port == 0) begin
         req0_valid = v; req0_rs = r; req0_nib = nb; req0_data = d;
      end else begin
         req1_valid = v; req1_rs = r; req1_nib = nb; req1_data = d;
      end
   endtask

   // Hold a request until n accepts; optionally push the timed nibbles for each accept.
   task automatic drive(input int port, input logic r, input logic nb, input logic [7:0] d,
                        input int n, input bit push, output int t_acc);
      int got   = 0;
      int guard = 0;
      t_acc = -1;
      set_req(port, 1'b1, r, nb, d);
      while (got < n && guard < 400) begin
         @(negedge clk);
         guard++;
         if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin
            got++;
            if (t_acc < 0) t_acc = cyc;
            if (push) begin
               exp_q.push_back('{cyc + 1, r, d[7:4]});
               if (!nb) exp_q.push_back('{cyc + 3, r, d[3:0]});
            end
         end
      end
      if (got < n) begin
         vecs++;
         miss++;
         $display("FAIL accept_timeout: requester %0d got %0d of %0d accepts", port, got, n);
      end
      @(posedge clk);
      #1;
      set_req(port, 1'b0, r, nb, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1;

      // Reset values
      repeat (2) @(posedge clk);
      #2;
      chk("rst_en", {31'd0, en}, 32'd0);
      chk("rst_rs", {31'd0, rs}, 32'd0);
      chk("rst_data", {28'd0, data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;

      // 1: reset asserted during LO_EN
      @(posedge clk); #1;
      exp_gnt.push_back(0);
      drive(0, 1'b0, 1'b0, CMD_FUNCSET_4B, 1, 1'b0, t0);
      exp_q.push_back('{t0 + 1, 1'b0, 4'h2});
      @(posedge clk); @(posedge clk); #2;
      chk("t1_lo_en", {31'd0, en}, 32'd1);
      chk("t1_lo_data", {28'd0, data}, 32'h8);
      set_req(0, 1'b1, 1'b1, 1'b0, 8'h41);
      set_req(1, 1'b1, 1'b1, 1'b0, 8'h30);
      reset = 1'b1;
      #1;
      chk("t1_async_en", {31'd0, en}, 32'd0);
      chk("t1_async_busy", {31'd0, busy}, 32'd0);
      chk("t1_async_data", {28'd0, data}, 32'd0);
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      chk("t1_ready0", {31'd0, req0_ready}, 32'd1);
      chk("t1_ready1", {31'd0, req1_ready}, 32'd0);
      #1;
      set_req(0, 1'b0, 1'b0, 1'b0, 8'h00);
      set_req(1, 1'b0, 1'b0, 1'b0, 8'h00);

      // 2: function set, then minimum spacing
      @(posedge clk); #1;
      exp_gnt.push_back(0);
      drive(0, 1'b0, 1'b0, CMD_FUNCSET_4B, 1, 1'b1, t0);
      exp_gnt.push_back(0);
      fork
         drive(0, 1'b0, 1'b0, CMD_DISPCTRL, 1, 1'b1, t1);
         begin
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               if (cyc == t0 + 5) chk("t2_busy_last", {31'd0, busy}, 32'd1);
               if (cyc == t0 + 6) begin
                  chk("t2_busy_fall", {31'd0, busy}, 32'd0);
                  break;
               end
            end
         end
      join
      chk("t2_gap", t1 - t0, 6);

      // 3: clear needs the long wait
      exp_gnt.push_back(0);
      drive(0, 1'b0, 1'b0, CMD_CLEAR, 1, 1'b1, t0);
      exp_gnt.push_back(0);
      drive(0, 1'b1, 1'b0, 8'h48, 1, 1'b1, t1);
      chk("t3_gap", t1 - t0, 7);

      // 4: nibble-only init steps
      exp_gnt.push_back(0);
      drive(0, 1'b0, 1'b1, 8'h30, 1, 1'b1, t0);
      exp_gnt.push_back(0);
      drive(0, 1'b0, 1'b1, 8'h20, 1, 1'b1, t1);
      chk("t4_gap", t1 - t0, 8);

      // 6: requester 1 stalls behind a home command
      exp_gnt.push_back(0);
      drive(0, 1'b0, 1'b0, CMD_HOME, 1, 1'b1, t0);
      exp_gnt.push_back(1);
      fork
         drive(1, 1'b1, 1'b0, 8'h4B, 1, 1'b1, t1);
         begin
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               if (!busy) break;
               chk("t6_stall", {31'd0, req1_ready}, 32'd0);
            end
         end
      join
      chk("t6_gap", t1 - t0, 7);

      // 5: both requesters continuously valid alternate 0,1,0,1
      for (int k = 0; k < 3; k++) begin
         exp_gnt.push_back(0);
         exp_gnt.push_back(1);
         exp_q.push_back('{-1, 1'b1, 4'h4});
         exp_q.push_back('{-1, 1'b1, 4'h1});
         exp_q.push_back('{-1, 1'b1, 4'h3});
         exp_q.push_back('{-1, 1'b1, 4'h0});
      end
      fork
         drive(0, 1'b1, 1'b0, 8'h41, 3, 1'b0, t0);
         drive(1, 1'b1, 1'b0, 8'h30, 3, 1'b0, t1);
      join
      chk("t5_first_gap", t1 - t0, 6);

      repeat (12) @(posedge clk);
      #1;
      chk("drain_nibbles", exp_q.size(), 0);
      chk("drain_grants", exp_gnt.size(), 0);
      chk("final_busy", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
